// File: rtl/module_keypad_scan.sv
// 4x4 matrix keypad scanner: one-hot column drive, synchronized row sensing,
// press/release debounce, and a one-cycle key_valid strobe per accepted key.
module module_keypad_scan #(
    parameter int unsigned SCAN_DIV     = 27000,
    parameter int unsigned DEBOUNCE_CYC = 540000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] filas_raw,
    output logic [3:0] columnas,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int unsigned CNT_W = 20;
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYC - 1);

    typedef enum logic [1:0] {
        SCAN       = 2'd0,
        PRESS_DB   = 2'd1,
        HOLD       = 2'd2,
        RELEASE_DB = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [3:0]       rows_meta, rows_s;
    logic [1:0]       col_idx, col_nxt;
    logic [1:0]       row_idx, row_nxt;
    logic [CNT_W-1:0] dwell_cnt, dwell_nxt;
    logic [CNT_W-1:0] db_cnt, db_nxt;
    logic [3:0]       code_nxt;
    logic             valid_nxt;
    logic [1:0]       low_row;

    // Hex legend printed on the keypad, indexed by {row, col}
    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
            4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
            4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
            4'hC: code = 4'hE;  4'hD: code = 4'h0;  4'hE: code = 4'hF;  default: code = 4'hD;
        endcase
        return code;
    endfunction

    // Lowest asserted row wins when several are pressed together
    always_comb begin
        if (rows_s[0])      low_row = 2'd0;
        else if (rows_s[1]) low_row = 2'd1;
        else if (rows_s[2]) low_row = 2'd2;
        else                low_row = 2'd3;
    end

    always_comb begin
        state_nxt = state;
        col_nxt   = col_idx;
        row_nxt   = row_idx;
        dwell_nxt = dwell_cnt;
        db_nxt    = db_cnt;
        code_nxt  = key_code;
        valid_nxt = 1'b0;
        case (state)
            SCAN: begin
                if (dwell_cnt == DWELL_LAST) begin
                    dwell_nxt = '0;
                    if (rows_s != 4'b0000) begin
                        row_nxt   = low_row;
                        db_nxt    = '0;
                        state_nxt = PRESS_DB;
                    end else begin
                        col_nxt = col_idx + 2'd1;
                    end
                end else begin
                    dwell_nxt = dwell_cnt + CNT_W'(1);
                end
            end
            PRESS_DB: begin
                if (!rows_s[row_idx]) begin
                    col_nxt   = col_idx + 2'd1;
                    dwell_nxt = '0;
                    state_nxt = SCAN;
                end else if (db_cnt == DB_LAST) begin
                    code_nxt  = key_map(row_idx, col_idx);
                    valid_nxt = 1'b1;
                    state_nxt = HOLD;
                end else begin
                    db_nxt = db_cnt + CNT_W'(1);
                end
            end
            HOLD: begin
                if (rows_s == 4'b0000) begin
                    db_nxt    = '0;
                    state_nxt = RELEASE_DB;
                end
            end
            default: begin
                if (rows_s != 4'b0000) begin
                    state_nxt = HOLD;
                end else if (db_cnt == DB_LAST) begin
                    col_nxt   = col_idx + 2'd1;
                    dwell_nxt = '0;
                    state_nxt = SCAN;
                end else begin
                    db_nxt = db_cnt + CNT_W'(1);
                end
            end
        endcase
    end

    // Column drive and key_held are registered from next-state so they track state exactly
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rows_meta <= 4'b0000;
            rows_s    <= 4'b0000;
            state     <= SCAN;
            col_idx   <= 2'd0;
            row_idx   <= 2'd0;
            dwell_cnt <= '0;
            db_cnt    <= '0;
            columnas  <= 4'b0001;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            rows_meta <= filas_raw;
            rows_s    <= rows_meta;
            state     <= state_nxt;
            col_idx   <= col_nxt;
            row_idx   <= row_nxt;
            dwell_cnt <= dwell_nxt;
            db_cnt    <= db_nxt;
            columnas  <= 4'b0001 << col_nxt;
            key_code  <= code_nxt;
            key_valid <= valid_nxt;
            key_held  <= (state_nxt == HOLD) || (state_nxt == RELEASE_DB);
        end
    end

endmodule

// File: tb/tb_module_keypad_scan.sv
// Directed bench for module_keypad_scan with SCAN_DIV=4, DEBOUNCE_CYC=8.
module tb_module_keypad_scan;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] filas_raw;
    logic [3:0] columnas;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    module_keypad_scan #(.SCAN_DIV(4), .DEBOUNCE_CYC(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .filas_raw (filas_raw),
        .columnas  (columnas),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Full output snapshot: {columnas, key_code}, key_valid, key_held
    task automatic chk_all(input string tag, input logic [3:0] col, input logic [3:0] code,
                           input logic vld, input logic held);
        chk({tag, ".columnas"}, 8'(columnas), 8'(col));
        chk({tag, ".key_code"}, 8'(key_code), 8'(code));
        chk({tag, ".key_valid"}, 8'(key_valid), 8'(vld));
        chk({tag, ".key_held"}, 8'(key_held), 8'(held));
    endtask

    initial begin
        rst_n     = 1'b0;
        filas_raw = 4'b0000;
        step(); step();
        chk_all("reset", 4'b0001, 4'h0, 1'b0, 1'b0);

        // Idle scan: each column driven for 4 cycles, wrapping after column 3
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            chk("idle_col", 8'(columnas), 8'(4'b0001 << ((k / 4) % 4)));
            chk("idle_valid", 8'(key_valid), 8'h0);
            step();
        end
        // Now column 1, dwell 0; four more cycles reach column 2
        step(); step(); step(); step();
        chk("reach_col2", 8'(columnas), 8'h4);

        // Row 1 on column 2 -> key 6 after sync(2) + dwell(2 more) + debounce(8)
        filas_raw = 4'b0010;
        for (int i = 1; i <= 11; i++) begin
            step();
            chk("press6_wait_valid", 8'(key_valid), 8'h0);
            chk("press6_frozen", 8'(columnas), 8'h4);
        end
        step();
        chk_all("press6_accept", 4'b0100, 4'h6, 1'b1, 1'b1);
        step();
        chk_all("press6_pulse_end", 4'b0100, 4'h6, 1'b0, 1'b1);

        // Short drop then re-press: back to HOLD, no second key_valid
        filas_raw = 4'b0000;
        step(); step(); step();
        filas_raw = 4'b0010;
        for (int i = 0; i < 6; i++) begin
            step();
            chk_all("rebounce", 4'b0100, 4'h6, 1'b0, 1'b1);
        end

        // Clean release: sync(2) + HOLD exit(1) + release debounce(8)
        filas_raw = 4'b0000;
        for (int i = 1; i <= 10; i++) begin
            step();
            chk("release_held", 8'(key_held), 8'h1);
            chk("release_valid", 8'(key_valid), 8'h0);
        end
        step();
        chk_all("release_done", 4'b1000, 4'h6, 1'b0, 1'b0);

        // Rows 1 and 3 on column 3: row 1 wins -> key B
        filas_raw = 4'b1010;
        for (int i = 1; i <= 11; i++) begin
            step();
            chk("pressB_wait_valid", 8'(key_valid), 8'h0);
        end
        step();
        chk_all("pressB_accept", 4'b1000, 4'hB, 1'b1, 1'b1);
        filas_raw = 4'b0000;
        for (int i = 0; i < 11; i++) step();
        chk_all("pressB_release", 4'b0001, 4'hB, 1'b0, 1'b0);

        // Bounce on column 0: 3 cycles high, then low -> abort, resume at column 1
        filas_raw = 4'b0001;
        step(); step(); step();
        filas_raw = 4'b0000;
        step(); step();
        chk_all("bounce_held_col", 4'b0001, 4'hB, 1'b0, 1'b0);
        step();
        chk_all("bounce_resume", 4'b0010, 4'hB, 1'b0, 1'b0);

        // Reset in the middle of the press debounce on column 1
        filas_raw = 4'b0001;
        for (int i = 0; i < 6; i++) step();
        chk("pre_reset_pressdb_col", 8'(columnas), 8'h2);
        rst_n     = 1'b0;
        filas_raw = 4'b0000;
        step();
        chk_all("reset_in_pressdb", 4'b0001, 4'h0, 1'b0, 1'b0);
        step();

        // Press key 1 from a fresh reset, then reset while in HOLD
        rst_n     = 1'b1;
        filas_raw = 4'b0001;
        for (int i = 1; i <= 11; i++) begin
            step();
            chk("press1_wait_valid", 8'(key_valid), 8'h0);
        end
        step();
        chk_all("press1_accept", 4'b0001, 4'h1, 1'b1, 1'b1);
        step(); step();
        rst_n = 1'b0;
        step();
        chk_all("reset_in_hold", 4'b0001, 4'h0, 1'b0, 1'b0);
        filas_raw = 4'b0000;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("post_reset_valid", 8'(key_valid), 8'h0);
            chk("post_reset_held", 8'(key_held), 8'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
